// File: rtl/pid_sample_sequencer.sv
// pid_sample_sequencer: periodic process-variable sampler plus a cycle-granular
// Wishbone arbiter sharing the PID core's slave port with a host master.
// Optional build macro PID_SEQ_OF_READ_EN: after each u(n) capture the sequencer
// reads the overflow flags at 0x28 and reports them on o_of.
module pid_sample_sequencer #(
  parameter int WB_NB     = 32,
  parameter int ADR_WB_NB = 16,
  parameter int DIV_NB    = 16,
  parameter int TMO_NB    = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_en,
  input  logic [DIV_NB-1:0]    i_period,
  input  logic [15:0]          i_pv,
  input  logic                 i_ovr_clr,
  input  logic                 i_h_cyc,
  input  logic                 i_h_stb,
  input  logic                 i_h_we,
  input  logic [ADR_WB_NB-1:0] i_h_adr,
  input  logic [WB_NB-1:0]     i_h_data,
  output logic                 o_h_ack,
  output logic [WB_NB-1:0]     o_h_data,
  output logic                 o_m_cyc,
  output logic                 o_m_stb,
  output logic                 o_m_we,
  output logic [ADR_WB_NB-1:0] o_m_adr,
  output logic [WB_NB-1:0]     o_m_data,
  input  logic                 i_m_ack,
  input  logic [WB_NB-1:0]     i_m_data,
  input  logic                 i_pid_valid,
  input  logic [31:0]          i_pid_un,
  output logic [31:0]          o_un,
  output logic                 o_un_valid,
  output logic [4:0]           o_of,
  output logic                 o_overrun,
  output logic                 o_tmo,
  output logic                 o_busy
);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WR, S_WLO, S_WHI, S_ROF} state_t;
  typedef enum logic [1:0] {G_NONE, G_HOST, G_SEQ} grant_t;

  localparam logic [ADR_WB_NB-1:0] ADR_PV    = ADR_WB_NB'(16'h0010);
  localparam logic [ADR_WB_NB-1:0] ADR_OF    = ADR_WB_NB'(16'h0028);
  localparam logic [TMO_NB-1:0]    TMO_LIMIT = '1;

  state_t                state, state_nxt;
  grant_t                grant, grant_nxt;
  logic [DIV_NB-1:0]     cnt;
  logic [TMO_NB-1:0]     tmo_cnt;
  logic signed [15:0]    pv_r;
  logic                  run, tick, seq_req;
  logic                  latch_pv, cap_un, cap_of, tmo_clr, tmo_hit;

  assign run      = i_en && (i_period != '0);
  assign tick     = run && (cnt == i_period);
  // Bus request: raised in the tick cycle itself so a same-cycle host request loses
  assign seq_req  = (state == S_IDLE && tick) || (state == S_REQ) ||
                    (state == S_WR) || (state == S_ROF);
  assign o_busy   = (state != S_IDLE);
  assign o_h_data = i_m_data;

  // Period counter: wraps at i_period (or above it after a shrink), held at 0 when stopped
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst)                      cnt <= '0;
    else if (!run || cnt >= i_period) cnt <= '0;
    else                             cnt <= cnt + 1'b1;
  end

  // Arbiter next grant: sequencer wins from NONE, owners keep the bus until their cyc drops
  always_comb begin
    grant_nxt = grant;
    case (grant)
      G_NONE:  if (seq_req) grant_nxt = G_SEQ;
               else if (i_h_cyc) grant_nxt = G_HOST;
      G_HOST:  if (!i_h_cyc) grant_nxt = seq_req ? G_SEQ : G_NONE;
      G_SEQ:   if (!seq_req) grant_nxt = i_h_cyc ? G_HOST : G_NONE;
      default: grant_nxt = G_NONE;
    endcase
  end

  // State and grant registers
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state <= S_IDLE;
      grant <= G_NONE;
    end else begin
      state <= state_nxt;
      grant <= grant_nxt;
    end
  end

  // Sequencer next state and per-cycle strobes
  always_comb begin
    state_nxt = state;
    latch_pv  = 1'b0;
    cap_un    = 1'b0;
    cap_of    = 1'b0;
    tmo_clr   = 1'b0;
    tmo_hit   = 1'b0;
    case (state)
      S_IDLE: if (tick) begin
        state_nxt = S_REQ;
        latch_pv  = 1'b1;
      end
      S_REQ:  if (grant_nxt == G_SEQ) state_nxt = S_WR;
      // Dropping stb after the ack lets the PID clear its own ack
      S_WR:   if (i_m_ack) begin
        state_nxt = S_WLO;
        tmo_clr   = 1'b1;
      end
      S_WLO:  if (!i_pid_valid) state_nxt = S_WHI;
              else if (tmo_cnt == TMO_LIMIT - 1'b1) begin
                state_nxt = S_IDLE;
                tmo_hit   = 1'b1;
              end
      S_WHI:  if (i_pid_valid) begin
        cap_un = 1'b1;
`ifdef PID_SEQ_OF_READ_EN
        state_nxt = S_ROF;
`else
        state_nxt = S_IDLE;
`endif
      end else if (tmo_cnt == TMO_LIMIT - 1'b1) begin
        state_nxt = S_IDLE;
        tmo_hit   = 1'b1;
      end
`ifdef PID_SEQ_OF_READ_EN
      S_ROF:  if (grant == G_SEQ && i_m_ack) begin
        state_nxt = S_IDLE;
        cap_of    = 1'b1;
      end
`endif
      default: state_nxt = S_IDLE;
    endcase
  end

  // Master-side mux: host passthrough, sequencer access, or idle bus
  always_comb begin
    o_m_cyc  = 1'b0;
    o_m_stb  = 1'b0;
    o_m_we   = 1'b0;
    o_m_adr  = '0;
    o_m_data = '0;
    o_h_ack  = 1'b0;
    if (grant == G_HOST) begin
      o_m_cyc  = i_h_cyc;
      o_m_stb  = i_h_stb;
      o_m_we   = i_h_we;
      o_m_adr  = i_h_adr;
      o_m_data = i_h_data;
      o_h_ack  = i_m_ack;
    end else if (grant == G_SEQ) begin
      o_m_cyc  = (state == S_WR) || (state == S_ROF);
      o_m_stb  = (state == S_WR) || (state == S_ROF);
      o_m_we   = (state == S_WR);
      o_m_adr  = (state == S_WR) ? ADR_PV : ((state == S_ROF) ? ADR_OF : '0);
      o_m_data = (state == S_WR) ? {{(WB_NB-16){pv_r[15]}}, pv_r} : '0;
    end
  end

  // Calculation timeout counter, live only while waiting on the PID handshake
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst)                                   tmo_cnt <= '0;
    else if (tmo_clr)                             tmo_cnt <= '0;
    else if (state == S_WLO || state == S_WHI)    tmo_cnt <= tmo_cnt + 1'b1;
  end

  // Sample holding register (data only, no reset needed)
  always_ff @(posedge i_clk) begin
    if (latch_pv) pv_r <= i_pv;
  end

  // Result capture, pulses and sticky overrun (a new overrun beats a clear)
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      o_un       <= '0;
      o_un_valid <= 1'b0;
      o_tmo      <= 1'b0;
      o_overrun  <= 1'b0;
    end else begin
      o_tmo <= tmo_hit;
      if (cap_un) o_un <= i_pid_un;
`ifdef PID_SEQ_OF_READ_EN
      o_un_valid <= cap_of;
`else
      o_un_valid <= cap_un;
`endif
      if (tick && state != S_IDLE) o_overrun <= 1'b1;
      else if (i_ovr_clr)          o_overrun <= 1'b0;
    end
  end

`ifdef PID_SEQ_OF_READ_EN
  // Overflow flags captured from the 0x28 read
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst)      o_of <= '0;
    else if (cap_of) o_of <= i_m_data[4:0];
  end
`else
  assign o_of = '0;
`endif

endmodule

// File: tb/tb_pid_sample_sequencer.sv
// Bench for pid_sample_sequencer: behavioural PID slave (ack, valid handshake,
// u = 0x20 - pv), scoreboard queues for pv writes and u(n) results, a vector
// table for sampling, and hand-written arbitration/overrun/timeout/reset sequences.
module tb_pid_sample_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en, ovr_clr;
  logic [15:0] period, pv;
  logic        h_cyc, h_stb, h_we;
  logic [15:0] h_adr;
  logic [31:0] h_wdata, h_rdata;
  logic        h_ack;
  logic        m_cyc, m_stb, m_we, m_ack;
  logic [15:0] m_adr;
  logic [31:0] m_wdata, m_rdata;
  logic        pid_valid;
  logic [31:0] pid_un, un;
  logic        un_valid, overrun, tmo, busy;
  logic [4:0]  of_flags;

  always #5 clk = ~clk;

  pid_sample_sequencer dut (
    .i_clk(clk), .i_rst(rst_n), .i_en(en), .i_period(period), .i_pv(pv),
    .i_ovr_clr(ovr_clr), .i_h_cyc(h_cyc), .i_h_stb(h_stb), .i_h_we(h_we),
    .i_h_adr(h_adr), .i_h_data(h_wdata), .o_h_ack(h_ack), .o_h_data(h_rdata),
    .o_m_cyc(m_cyc), .o_m_stb(m_stb), .o_m_we(m_we), .o_m_adr(m_adr),
    .o_m_data(m_wdata), .i_m_ack(m_ack), .i_m_data(m_rdata),
    .i_pid_valid(pid_valid), .i_pid_un(pid_un), .o_un(un), .o_un_valid(un_valid),
    .o_of(of_flags), .o_overrun(overrun), .o_tmo(tmo), .o_busy(busy)
  );

  localparam int         PID_LAT = 10;
  localparam logic [4:0] OF_VAL  = 5'b11000;
`ifdef PID_SEQ_OF_READ_EN
  localparam logic [4:0]  EXP_OF  = OF_VAL;
  localparam logic [15:0] RST_ADR = 16'h0028;
`else
  localparam logic [4:0]  EXP_OF  = 5'b00000;
  localparam logic [15:0] RST_ADR = 16'h0010;
`endif

  int          checks = 0;
  int          errors = 0;
  int          n;
  logic        wr_seen;
  logic [31:0] last_un;
  logic        stuck, calc;
  int          lat_cnt;
  logic [31:0] calc_pv;
  logic [31:0] exp_wr[$];
  logic [31:0] exp_un[$];

  typedef struct {
    logic [15:0] pv;
    logic [15:0] period;
    logic [31:0] wdata;
    logic [31:0] un;
  } vec_t;
  vec_t vecs[5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic push_exp(input logic [31:0] wdata, input logic [31:0] u);
    exp_wr.push_back(wdata);
    exp_un.push_back(u);
    last_un = u;
  endtask

  // Counts clock edges until the sequencer's pv write strobe is visible
  task automatic wait_wr_start(input int bound, output int cnt);
    cnt = 0;
    do begin
      @(posedge clk); @(negedge clk);
      cnt++;
    end while (!(m_cyc && m_stb && m_we && m_adr == 16'h0010) && cnt < bound);
  endtask

  task automatic wait_done(input int bound);
    int k = 0;
    while ((exp_un.size() != 0 || busy) && k < bound) begin
      @(negedge clk);
      k++;
    end
    chk("sample_completes", {exp_un.size() != 0, busy}, 64'd0);
  endtask

  // PID slave model: one-cycle ack, valid drops then returns with u = 0x20 - pv
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ack <= 1'b0; pid_valid <= 1'b1; pid_un <= '0;
      calc <= 1'b0; lat_cnt <= 0; calc_pv <= '0;
    end else begin
      m_ack <= m_cyc && m_stb && !m_ack;
      if (m_cyc && m_stb && !m_ack && m_we && m_adr == 16'h0010) begin
        calc <= 1'b1; lat_cnt <= 0; calc_pv <= m_wdata;
      end else if (calc && !stuck) begin
        pid_valid <= 1'b0;
        lat_cnt   <= lat_cnt + 1;
        if (lat_cnt == PID_LAT) begin
          pid_valid <= 1'b1;
          pid_un    <= 32'h0000_0020 - calc_pv;
          calc      <= 1'b0;
        end
      end
    end
  end
  assign m_rdata = (m_adr == 16'h0028) ? {27'd0, OF_VAL} : {16'hA5A5, m_adr};

  // Scoreboard: pops expected pv writes and u(n) results as the DUT produces them
  always @(negedge clk) begin
    if (rst_n) begin
      if (m_cyc && m_stb && m_ack && m_we && m_adr == 16'h0010) begin
        if (exp_wr.size() == 0) chk("unexpected_pv_write", {32'd1, m_wdata}, 64'd0);
        else chk("pv_write_data", m_wdata, exp_wr.pop_front());
      end
      if (un_valid) begin
        if (exp_un.size() == 0) chk("unexpected_un_valid", {32'd1, un}, 64'd0);
        else chk("un_and_of", {un, of_flags}, {exp_un.pop_front(), EXP_OF});
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{pv: 16'h0010, period: 16'd99, wdata: 32'h0000_0010, un: 32'h0000_0010};
    vecs[1] = '{pv: 16'h8000, period: 16'd40, wdata: 32'hFFFF_8000, un: 32'h0000_8020};
    vecs[2] = '{pv: 16'hFFFF, period: 16'd31, wdata: 32'hFFFF_FFFF, un: 32'h0000_0021};
    vecs[3] = '{pv: 16'h7FFF, period: 16'd50, wdata: 32'h0000_7FFF, un: 32'hFFFF_8021};
    vecs[4] = '{pv: 16'h0020, period: 16'd35, wdata: 32'h0000_0020, un: 32'h0000_0000};

    rst_n = 1'b0; en = 1'b0; ovr_clr = 1'b0; period = '0; pv = '0; stuck = 1'b0;
    h_cyc = 1'b0; h_stb = 1'b0; h_we = 1'b0; h_adr = '0; h_wdata = '0; last_un = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {m_cyc, m_stb, m_we, h_ack, un_valid, of_flags, overrun, tmo, busy, un}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_after_reset", {busy, m_cyc, h_ack}, 64'd0);

    // Sampling vectors: tick-to-write latency and sign-extended write data
    for (int i = 0; i < 5; i++) begin
      pv = vecs[i].pv; period = vecs[i].period;
      push_exp(vecs[i].wdata, vecs[i].un);
      en = 1'b1;
      wait_wr_start(300, n);
      en = 1'b0;
      chk($sformatf("tick_to_wr_%0d", i), n, vecs[i].period + 2);
      wait_done(100);
    end

    // Period shrunk below the running count: wrap to 0, then count to the new value
    pv = 16'h0003; period = 16'd50; push_exp(32'h0000_0003, 32'h0000_001D);
    en = 1'b1;
    repeat (30) @(posedge clk);
    @(negedge clk);
    period = 16'd10;
    wait_wr_start(100, n);
    en = 1'b0;
    chk("period_shrink_wrap", n, 13);
    wait_done(100);

    // Host holds the bus across a tick: sequencer waits in REQ
    pv = 16'h0005; period = 16'd20; push_exp(32'h0000_0005, 32'h0000_001B);
    h_adr = 16'h0004; h_we = 1'b0; h_cyc = 1'b1; h_stb = 1'b1; en = 1'b1;
    n = 0;
    while (!busy && n < 50) begin @(negedge clk); n++; end
    en = 1'b0;
    repeat (5) @(negedge clk);
    chk("host_keeps_bus", {busy, m_cyc, m_we, m_adr}, {1'b1, 1'b1, 1'b0, 16'h0004});
    n = 0;
    while (!h_ack && n < 10) begin @(negedge clk); n++; end
    chk("host_read_data", {h_ack, h_rdata}, {1'b1, 32'hA5A5_0004});
    h_cyc = 1'b0; h_stb = 1'b0;
    @(negedge clk);
    chk("wr_after_host_drop", {m_stb, m_we, m_adr}, {1'b1, 1'b1, 16'h0010});
    wait_done(100);

    // Host and tick in the same cycle from NONE: sequencer granted first
    pv = 16'h0008; period = 16'd30; push_exp(32'h0000_0008, 32'h0000_0018);
    en = 1'b1;
    repeat (30) @(posedge clk);
    @(negedge clk);
    h_cyc = 1'b1; h_stb = 1'b1; h_adr = 16'h0004;
    @(negedge clk);
    en = 1'b0;
    chk("same_cycle_seq_granted", {busy, m_cyc, h_ack}, 3'b100);
    @(negedge clk);
    chk("same_cycle_wr", {m_stb, m_we, m_adr}, {1'b1, 1'b1, 16'h0010});
    wr_seen = 1'b0; n = 0;
    while (!h_ack && n < 40) begin
      if (m_stb && m_we && m_ack) wr_seen = 1'b1;
      @(negedge clk);
      n++;
    end
    chk("host_ack_after_seq_write", {h_ack, wr_seen}, 2'b11);
    h_cyc = 1'b0; h_stb = 1'b0;
    wait_done(100);

    // Overrun on a tick while busy, sticky until cleared
    pv = 16'h0001; period = 16'd3; push_exp(32'h0000_0001, 32'h0000_001F);
    en = 1'b1;
    n = 0;
    while (!overrun && n < 40) begin @(negedge clk); n++; end
    en = 1'b0;
    chk("overrun_set", overrun, 1'b1);
    wait_done(100);
    chk("overrun_sticky", overrun, 1'b1);
    ovr_clr = 1'b1;
    @(negedge clk);
    ovr_clr = 1'b0;
    chk("overrun_clear", overrun, 1'b0);

    // Clear held while a new overrun occurs: set wins, next cycle clears
    pv = 16'h0002; period = 16'd3; push_exp(32'h0000_0002, 32'h0000_001E);
    ovr_clr = 1'b1; en = 1'b1;
    n = 0;
    while (!overrun && n < 40) begin @(negedge clk); n++; end
    en = 1'b0;
    chk("overrun_beats_clear", overrun, 1'b1);
    @(negedge clk);
    chk("clear_after_overrun", overrun, 1'b0);
    ovr_clr = 1'b0;
    wait_done(100);

    // PID valid never drops: timeout pulse, o_un unchanged
    stuck = 1'b1; pv = 16'h0004; period = 16'd10;
    exp_wr.push_back(32'h0000_0004);
    en = 1'b1;
    n = 0;
    while (!(m_stb && m_we && m_ack) && n < 50) begin @(negedge clk); n++; end
    en = 1'b0;
    n = 0;
    do begin @(posedge clk); @(negedge clk); n++; end while (!tmo && n < 300);
    chk("tmo_latency", n, 256);
    chk("tmo_idle_un_kept", {busy, un}, {1'b0, last_un});
    @(negedge clk);
    chk("tmo_single_pulse", tmo, 1'b0);
    stuck = 1'b0;
    repeat (20) @(negedge clk);

    // Asynchronous reset in the middle of a sequencer bus cycle
    pv = 16'h0006; period = 16'd5; push_exp(32'h0000_0006, 32'h0000_001A);
    en = 1'b1;
    n = 0;
    while (!(m_stb && m_adr == RST_ADR) && n < 80) begin @(negedge clk); n++; end
    en = 1'b0;
    chk("reached_mid_cycle", {m_cyc, m_adr}, {1'b1, RST_ADR});
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", {m_cyc, m_stb, m_we, h_ack, un_valid, of_flags, overrun, tmo, busy, un}, 64'd0);
    exp_wr.delete();
    exp_un.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_idle", {busy, m_cyc, un}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pid_sample_sequencer.md
Name: pid_sample_sequencer

Overview:
- Periodic sampling controller and Wishbone arbiter placed in front of the PID core's Wishbone slave port.
- On each sample tick it latches the process variable and writes it to the PID pv register, which triggers the e(n)/sigma/u(n) update.
- It then waits for the core's u(n) valid handshake and captures u(n).
- A host Wishbone master shares the same slave port through a cycle-granular arbiter.

Parameters:
- WB_NB, 32, Wishbone data width; 32-bit map (pv at 0x10, OF at 0x28).
- ADR_WB_NB, 16, Wishbone address width.
- DIV_NB, 16, sample-period counter width.
- TMO_NB, 8, calculation-timeout counter width; timeout limit = 2^TMO_NB-1 cycles.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  asynchronous, active-low reset
- i_en  in  1  sampling enable
- i_period  in  DIV_NB  tick every i_period+1 cycles; 0 disables ticks
- i_pv  in  16  process variable sample, latched at tick
- i_ovr_clr  in  1  clears o_overrun
- i_h_cyc, i_h_stb, i_h_we  in  1 each  host Wishbone master controls
- i_h_adr  in  ADR_WB_NB  host address
- i_h_data  in  WB_NB  host write data
- o_h_ack  out  1  host ack
- o_h_data  out  WB_NB  host read data
- o_m_cyc, o_m_stb, o_m_we  out  1 each  controls to PID slave
- o_m_adr  out  ADR_WB_NB  address to PID slave
- o_m_data  out  WB_NB  write data to PID slave
- i_m_ack  in  1  PID ack
- i_m_data  in  WB_NB  PID read data
- i_pid_valid  in  1  PID o_valid
- i_pid_un  in  32  PID o_un
- o_un  out  32  captured u(n)
- o_un_valid  out  1  one-cycle pulse when o_un updates
- o_of  out  5  captured overflow flags
- o_overrun  out  1  sticky: tick lost
- o_tmo  out  1  one-cycle pulse: calculation timeout
- o_busy  out  1  sequencer not IDLE

Behaviour:
- Reset values: all outputs 0; FSM IDLE; grant NONE; period counter 0.
- Tick generation:
  - The counter increments while i_en=1 and i_period!=0.
  - When the counter equals i_period, one-cycle tick and counter returns to 0.
  - i_en=0 holds the counter at 0.
  - Changing i_period mid-count takes effect on the next compare; if the counter exceeds the new value, it wraps to 0.
- Tick in IDLE: latch pv_r<=i_pv and go to REQ.
- Tick in any other state: tick dropped and o_overrun<=1.
- o_overrun clear: i_ovr_clr=1 clears o_overrun; a simultaneous overrun wins (stays set).
- Arbiter (grant register NONE/HOST/SEQ):
  - From NONE: sequencer request has priority -> SEQ; else i_h_cyc=1 -> HOST. Transition takes one cycle.
  - HOST is released when i_h_cyc=0. SEQ is released when the sequencer's cyc drops.
  - Grant never changes mid-cycle.
  - When HOST: o_m_* = host signals combinationally, o_h_ack=i_m_ack.
  - When not HOST: o_h_ack=0 (host sees wait states); o_m_* driven by the sequencer, or all 0 when NONE.
  - o_h_data=i_m_data always.
- Sequencer FSM:
  - IDLE -> REQ on tick.
  - REQ: request bus; on grant SEQ -> WR.
  - WR: cyc=stb=we=1, adr=0x10, data=sign-extended pv_r.
  - WR, on i_m_ack: next edge drop cyc/stb -> WLO. The PID needs stb low to clear its ack.
  - WLO: wait i_pid_valid=0, then -> WHI.
  - WHI: wait i_pid_valid=1, then o_un<=i_pid_un, o_un_valid pulse -> IDLE.
  - Timeout counter: cleared on entry to WLO, runs through WLO+WHI. At limit: o_tmo pulse, o_un unchanged -> IDLE.
- Latency: tick to WR stb is 2 cycles when the bus is free. Total latency is set by the PID core (~16 cycles).
- Host writes to pv or coefficients while SEQ owns the bus are deferred by the arbiter, never corrupted.
- Reset mid-cycle: immediate return to reset values; o_m_cyc drops asynchronously.

Optional Feature:
- Macro: PID_SEQ_OF_READ_EN.
- Defined: after WHI capture, FSM enters ROF.
  - ROF: re-request bus -> read adr 0x28 (we=0); on ack o_of<=i_m_data[4:0], drop cyc -> IDLE.
  - o_un_valid pulses on o_of update instead of at WHI.
  - Ticks during ROF count as overrun.
- Undefined: no ROF state; o_of tied to 0; o_un_valid pulses at WHI capture.

Test Plan:
- i_period=99, i_en=1, i_pv=0x0010, PID sp=0x0020 (kp=1, ki=kd=0) -> one pv write per 100 cycles at adr 0x10, data 0x00000010; o_un_valid pulses, o_un matches PID un.
- Host holds i_h_cyc during tick -> sequencer waits in REQ; WR starts the cycle after host cyc drops; no host ack lost.
- Host and tick request in the same cycle from NONE -> SEQ granted; host ack only after sequencer completes.
- i_period=3 with PID latency >4 -> o_overrun=1, tick dropped; i_ovr_clr clears it; a simultaneous clear plus overrun stays 1.
- i_pid_valid held 1 (no drop) -> o_tmo pulse after 255 cycles in WLO; FSM IDLE; o_un unchanged.
- PID_SEQ_OF_READ_EN defined, force sigma overflow -> read at 0x28 follows capture; o_of=5'b11000; i_rst low mid-read -> all outputs 0 immediately.
